instr_fetch_unit: RTL

- Instruction-fetch stage of the single-cycle MIPS datapath, directly upstream of control_u.
- Holds the PC and a word-addressed instruction memory, and slices the current instruction into fields; op_code and funct feed control_u.
- Computes the next PC from sequential, branch and jump sources, and halts cleanly when the PC leaves memory.

---
 rtl/instr_fetch_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: PC register, word-addressed instruction memory, field slicing
// and next-PC selection. Define FETCH_PERF_EN to add the saturating fetch counter.
module instr_fetch_unit #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          jump,
  input  logic                          branch_taken,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  output logic [31:0]                   pc,
  output logic [31:0]                   pc_plus4,
  output logic [31:0]                   instr,
  output logic [5:0]                    op_code,
  output logic [4:0]                    rs,
  output logic [4:0]                    rt,
  output logic [4:0]                    rd,
  output logic [4:0]                    shamt,
  output logic [5:0]                    funct,
  output logic [15:0]                   imm16,
  output logic                          valid,
  output logic                          halted,
  output logic [31:0]                   instr_count
);

  localparam int unsigned AW = $clog2(IMEM_DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] next_pc;
  logic [31:0] br_off;
  logic [31:0] imem [IMEM_DEPTH];

  // Program-load port; a read of the same word this cycle still sees the old data
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign instr    = (state_q == ST_HALTED) ? 32'h0 : imem[pc_q[AW+1:2]];

  assign op_code  = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm16    = instr[15:0];

  assign valid    = (state_q == ST_RUN);
  assign halted   = (state_q == ST_HALTED);

  assign br_off   = {{14{instr[15]}}, instr[15:0], 2'b00};

  // Jump outranks branch; sequential fetch is the fallback
  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_plus4 + br_off;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!stall) begin
          pc_d = next_pc;
          // The escaping PC is kept so the faulting target stays visible
          if ((next_pc >> 2) >= 32'(IMEM_DEPTH)) begin
            state_d = ST_HALTED;
          end
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == ST_RUN) && !stall && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 32'h0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign instr_count = cnt_q;
`else
  assign instr_count = 32'h0;
`endif

endmodule
